// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel FIFO write side and the sync controller's unpack.
// Packed word layout, raster counter width and FSM state encoding.
package pixel_pkg;

  localparam int PIX_W = 44;
  localparam int XY_W  = 10;

  localparam int X_MSB = 43;
  localparam int X_LSB = 34;
  localparam int Y_MSB = 33;
  localparam int Y_LSB = 24;
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic [XY_W-1:0] XY_MAX = '1;

  typedef enum logic {
    S_WAIT_VS = 1'b0,
    S_RUN     = 1'b1
  } wr_state_e;

  function automatic logic [PIX_W-1:0] pack_pix(input logic [XY_W-1:0] x,
                                                input logic [XY_W-1:0] y,
                                                input logic [7:0]      r,
                                                input logic [7:0]      g,
                                                input logic [7:0]      b);
    return {x, y, r, g, b};
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Small register FIFO that absorbs short FIFO-full stalls on the pixel write side.
// DEPTH must be a power of two so the pointers wrap naturally.
module pix_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic         clk_25,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Push into the slot being popped is safe: dout reads the old contents this cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_fifo_writer.sv
// Write side of the ColorTransform pixel FIFO: vsync-framed raster tracking, decimation,
// skid buffering in front of the FIFO and sticky overflow / dropped-pixel accounting.
//
//   state     | meaning
//   S_WAIT_VS | capture idle, counters held at 0, waiting for a vsync edge with en=1
//   S_RUN     | capturing pixels of the current frame
module pixel_fifo_writer
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DECIM  = 1,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pix_vs,
  input  logic              pix_de,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [PIX_W-1:0]  data,
  output logic              frame_start,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [15:0]       drop_cnt
);

  localparam logic [XY_W-1:0] DECIM_M1 = XY_W'(DECIM - 1);

  wr_state_e       state_q, state_d;
  logic            vs_act_q, vs_act_d;
  logic            de_q, de_d;
  logic            frame_start_q, frame_start_d;
  logic [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic [XY_W-1:0] x_ph_q, x_ph_d, y_ph_q, y_ph_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic vs_act, vs_edge, keep, push, pop, drop;
  logic skid_full, skid_empty;
  logic [PIX_W-1:0] skid_din;

  assign vs_act  = (pix_vs == VS_POL);
  assign vs_edge = vs_act && !vs_act_q;

  // A pixel coinciding with a vsync edge belongs to no frame and is not captured.
  assign keep = (state_q == S_RUN) && !vs_edge && pix_de &&
                (x_ph_q == '0) && (y_ph_q == '0);
  assign pop  = !skid_empty && !wrfull;
  assign push = keep && (!skid_full || pop);
  assign drop = keep && skid_full && !pop;

  assign skid_din    = pack_pix(x_q, y_q, pix_r, pix_g, pix_b);
  assign wrreq       = pop;
  assign frame_start = frame_start_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_cnt_q;

  pix_skid_fifo #(
    .DEPTH(DEPTH),
    .W    (PIX_W)
  ) u_skid (
    .clk_25(clk_25),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (skid_din),
    .dout  (data),
    .full  (skid_full),
    .empty (skid_empty)
  );

  always_comb begin
    state_d       = state_q;
    vs_act_d      = vs_act;
    de_d          = pix_de;
    frame_start_d = vs_edge;
    x_d           = x_q;
    y_d           = y_q;
    x_ph_d        = x_ph_q;
    y_ph_d        = y_ph_q;
    ovf_d         = ovf_q;
    drop_cnt_d    = drop_cnt_q;

    if (vs_edge) begin
      state_d = en ? S_RUN : S_WAIT_VS;
    end

    // Phases only advance with their coordinate so they always equal coord % DECIM.
    if (vs_edge || (state_q == S_WAIT_VS)) begin
      x_d    = '0;
      y_d    = '0;
      x_ph_d = '0;
      y_ph_d = '0;
    end else if (pix_de) begin
      if (x_q != XY_MAX) begin
        x_d    = x_q + 1'b1;
        x_ph_d = (x_ph_q == DECIM_M1) ? '0 : x_ph_q + 1'b1;
      end
    end else if (de_q) begin
      x_d    = '0;
      x_ph_d = '0;
      if (y_q != XY_MAX) begin
        y_d    = y_q + 1'b1;
        y_ph_d = (y_ph_q == DECIM_M1) ? '0 : y_ph_q + 1'b1;
      end
    end

    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // vs_act resets to "active" so a vsync already asserted at reset release is not an edge.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_VS;
      vs_act_q      <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      x_ph_q        <= '0;
      y_ph_q        <= '0;
      ovf_q         <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      vs_act_q      <= vs_act_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      x_ph_q        <= x_ph_d;
      y_ph_q        <= y_ph_d;
      ovf_q         <= ovf_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Bench for pixel_fifo_writer: two instances (DECIM=1 and DECIM=2) checked every cycle
// against a queue-based frame/raster model, plus literal checks on the directed scenarios.
`timescale 1ns/1ps
module tb_pixel_fifo_writer;

  localparam int DEP = 4;

  logic clk_25 = 1'b0;
  logic rst_n;
  logic en, pix_vs, pix_de, wrfull, clr_ovf;
  logic [7:0] pix_r, pix_g, pix_b;

  logic        wrreq_o       [2];
  logic [43:0] data_o        [2];
  logic        frame_start_o [2];
  logic        overflow_o    [2];
  logic [15:0] drop_cnt_o    [2];

  int n_vec = 0;
  int n_err = 0;

  always #20 clk_25 = ~clk_25;

  pixel_fifo_writer #(.DEPTH(DEP), .DECIM(1), .VS_POL(1'b1)) u_dut0 (
    .clk_25(clk_25), .rst_n(rst_n), .en(en), .pix_vs(pix_vs), .pix_de(pix_de),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .wrfull(wrfull),
    .wrreq(wrreq_o[0]), .data(data_o[0]), .frame_start(frame_start_o[0]),
    .overflow(overflow_o[0]), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt_o[0]));

  pixel_fifo_writer #(.DEPTH(DEP), .DECIM(2), .VS_POL(1'b1)) u_dut1 (
    .clk_25(clk_25), .rst_n(rst_n), .en(en), .pix_vs(pix_vs), .pix_de(pix_de),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .wrfull(wrfull),
    .wrreq(wrreq_o[1]), .data(data_o[1]), .frame_start(frame_start_o[1]),
    .overflow(overflow_o[1]), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt_o[1]));

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] w(input int x, input int y, input int r);
    return {10'(x), 10'(y), 8'(r), 8'(r + 10), 8'(r + 20)};
  endfunction

  // ---------------- behavioural model ----------------
  int          decim [2] = '{1, 2};
  logic [43:0] m_skid [2][$];
  int          m_x [2], m_y [2], m_drop [2];
  bit          m_run [2], m_ovf [2];
  bit          m_fs, m_vs_prev, m_de_prev;

  always @(posedge clk_25 or negedge rst_n) begin
    bit edge_v, keep, dropped;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_skid[i].delete();
        m_x[i] = 0; m_y[i] = 0; m_drop[i] = 0; m_run[i] = 0; m_ovf[i] = 0;
      end
      m_fs = 0; m_vs_prev = 1; m_de_prev = 0;
    end else begin
      edge_v = pix_vs && !m_vs_prev;
      for (int i = 0; i < 2; i++) begin
        if (m_skid[i].size() != 0 && !wrfull) void'(m_skid[i].pop_front());
        keep = m_run[i] && !edge_v && pix_de &&
               (m_x[i] % decim[i] == 0) && (m_y[i] % decim[i] == 0);
        dropped = 0;
        if (keep) begin
          if (m_skid[i].size() < DEP)
            m_skid[i].push_back({10'(m_x[i]), 10'(m_y[i]), pix_r, pix_g, pix_b});
          else
            dropped = 1;
        end
        if (clr_ovf) begin
          m_ovf[i] = 0; m_drop[i] = 0;
        end else if (dropped) begin
          m_ovf[i] = 1;
          if (m_drop[i] < 65535) m_drop[i]++;
        end
        if (edge_v) begin
          m_x[i] = 0; m_y[i] = 0; m_run[i] = en;
        end else if (!m_run[i]) begin
          m_x[i] = 0; m_y[i] = 0;
        end else if (pix_de) begin
          if (m_x[i] < 1023) m_x[i]++;
        end else if (m_de_prev) begin
          m_x[i] = 0;
          if (m_y[i] < 1023) m_y[i]++;
        end
      end
      m_fs = edge_v;
      m_vs_prev = pix_vs;
      m_de_prev = pix_de;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [43:0] wlog [2][$];
  int          fs_cnt [2] = '{0, 0};

  always @(negedge clk_25) begin
    bit exp_wr;
    for (int i = 0; i < 2; i++) begin
      exp_wr = (m_skid[i].size() != 0) && !wrfull;
      chk("wrreq", i, 64'(wrreq_o[i]), 64'(exp_wr));
      if (exp_wr) chk("data", i, 64'(data_o[i]), 64'(m_skid[i][0]));
      chk("overflow", i, 64'(overflow_o[i]), 64'(m_ovf[i]));
      chk("drop_cnt", i, 64'(drop_cnt_o[i]), 64'(m_drop[i]));
      chk("frame_start", i, 64'(frame_start_o[i]), 64'(m_fs));
      if (wrreq_o[i] === 1'b1) wlog[i].push_back(data_o[i]);
      if (frame_start_o[i] === 1'b1) fs_cnt[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic pix(input int r);
    pix_de = 1'b1;
    pix_r = 8'(r); pix_g = 8'(r + 10); pix_b = 8'(r + 20);
    tick();
  endtask

  task automatic idle(input int n);
    pix_de = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vsync();
    pix_de = 1'b0;
    pix_vs = 1'b1; tick();
    pix_vs = 1'b0; tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, f0;
    rst_n = 0; en = 0; pix_vs = 0; pix_de = 0; wrfull = 0; clr_ovf = 0;
    pix_r = 0; pix_g = 0; pix_b = 0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_wrreq", i, 64'(wrreq_o[i]), 64'd0);
      chk("rst_data", i, 64'(data_o[i]), 64'd0);
      chk("rst_drop", i, 64'(drop_cnt_o[i]), 64'd0);
    end
    rst_n = 1;
    idle(2);

    // 1: single 4-pixel line
    en = 1; vsync(); idle(2);
    b0 = wlog[0].size();
    for (int k = 0; k < 4; k++) pix(10 + k);
    idle(4);
    chk("t1_writes", 0, 64'(wlog[0].size() - b0), 64'd4);
    chk("t1_first", 0, 64'(wlog[0][b0]), 64'(w(0, 0, 10)));
    chk("t1_last", 0, 64'(wlog[0][b0 + 3]), 64'(w(3, 0, 13)));

    // 2: two 640-pixel lines
    vsync(); idle(2);
    b0 = wlog[0].size(); b1 = wlog[1].size();
    for (int ln = 0; ln < 2; ln++) begin
      for (int k = 0; k < 640; k++) pix(k);
      idle(10);
    end
    chk("t2_writes_d2", 1, 64'(wlog[1].size() - b1), 64'd320);
    chk("t2_last_d2", 1, 64'(wlog[1][b1 + 319]), 64'(w(638, 0, 638)));
    chk("t2_writes_d1", 0, 64'(wlog[0].size() - b0), 64'd1280);

    // 3: FIFO full for 6 pixels
    vsync(); idle(2);
    wrfull = 1;
    for (int k = 0; k < 6; k++) pix(40 + k);
    idle(1);
    chk("t3_overflow", 0, 64'(overflow_o[0]), 64'd1);
    chk("t3_drop", 0, 64'(drop_cnt_o[0]), 64'd2);
    b0 = wlog[0].size();
    wrfull = 0; idle(6);
    chk("t3_writes", 0, 64'(wlog[0].size() - b0), 64'd4);
    chk("t3_first", 0, 64'(wlog[0][b0]), 64'(w(0, 0, 40)));
    chk("t3_last", 0, 64'(wlog[0][b0 + 3]), 64'(w(3, 0, 43)));
    clr_ovf = 1; tick(); clr_ovf = 0;
    chk("t3_clr", 0, 64'(overflow_o[0]), 64'd0);

    // 4: disabled frame then re-enable
    en = 0;
    b0 = wlog[0].size(); f0 = fs_cnt[0];
    vsync(); idle(2);
    for (int k = 0; k < 8; k++) pix(60 + k);
    idle(4);
    chk("t4_no_writes", 0, 64'(wlog[0].size() - b0), 64'd0);
    chk("t4_fs", 0, 64'(fs_cnt[0] - f0), 64'd1);
    en = 1; vsync(); idle(2);
    b0 = wlog[0].size();
    pix(70); pix(71); idle(3);
    chk("t4_resume", 0, 64'(wlog[0].size() - b0), 64'd2);
    chk("t4_first", 0, 64'(wlog[0][b0]), 64'(w(0, 0, 70)));

    // 5: reset mid-line with 3 words buffered
    vsync(); idle(2);
    wrfull = 1;
    for (int k = 0; k < 3; k++) pix(80 + k);
    rst_n = 0; wrfull = 0; pix_de = 1;
    #1;
    chk("t5_wrreq", 0, 64'(wrreq_o[0]), 64'd0);
    chk("t5_data", 0, 64'(data_o[0]), 64'd0);
    chk("t5_fs", 0, 64'(frame_start_o[0]), 64'd0);
    tick(); tick();
    rst_n = 1;
    b0 = wlog[0].size();
    for (int k = 0; k < 5; k++) pix(90 + k);
    idle(4);
    chk("t5_no_writes", 0, 64'(wlog[0].size() - b0), 64'd0);

    // 6: clr vs drop priority, then saturation
    vsync(); idle(2);
    wrfull = 1;
    for (int k = 0; k < 4; k++) pix(100 + k);
    clr_ovf = 1; pix(104); clr_ovf = 0;
    chk("t6_clr_ovf", 0, 64'(overflow_o[0]), 64'd0);
    chk("t6_clr_drop", 0, 64'(drop_cnt_o[0]), 64'd0);
    pix_de = 1;
    repeat (65540) tick();
    chk("t6_sat", 0, 64'(drop_cnt_o[0]), 64'hFFFF);
    chk("t6_ovf", 0, 64'(overflow_o[0]), 64'd1);
    wrfull = 0; idle(10);
    clr_ovf = 1; tick(); clr_ovf = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
